// File: rtl/filter_pkg.sv
// Shared coefficient formats, limits, reset values and ramp FSM states for the
// state-variable filter parameter path.
package filter_pkg;

  localparam int COEF_W = 20;

  localparam logic signed [COEF_W-1:0] F_MAX        = 20'sd288358;
  localparam logic signed [COEF_W-1:0] Q1_MAX       = 20'sd131072;
  localparam logic signed [COEF_W-1:0] F_RESET_DEF  = 20'sd13176;
  localparam logic signed [COEF_W-1:0] Q1_RESET_DEF = 20'sd92682;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    STEP = 2'd2
  } ramp_state_t;

  // Negative requests collapse to zero so the filter never sees a negative coefficient.
  function automatic logic signed [COEF_W-1:0] clamp_coef(
    input logic signed [COEF_W-1:0] v,
    input logic signed [COEF_W-1:0] hi
  );
    if (v < 0) return '0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/svf_slew_step.sv
// One smoothing step: moves cur toward target by diff>>>STEP_SHIFT, at least one LSB.
module svf_slew_step
  import filter_pkg::*;
#(
  parameter int STEP_SHIFT = 6
) (
  input  logic signed [COEF_W-1:0] cur,
  input  logic signed [COEF_W-1:0] target,
  output logic signed [COEF_W-1:0] next_val
);

  logic signed [COEF_W:0] diff;
  logic signed [COEF_W:0] step;
  logic signed [COEF_W:0] sum;

  always_comb begin
    diff = {target[COEF_W-1], target} - {cur[COEF_W-1], cur};
    step = diff >>> STEP_SHIFT;
    // Small residues would otherwise stall short of the target.
    if (step == '0 && diff != '0) begin
      step = diff[COEF_W] ? '1 : {{COEF_W{1'b0}}, 1'b1};
    end
    sum      = {cur[COEF_W-1], cur} + step;
    next_val = sum[COEF_W-1:0];
  end

endmodule

// File: rtl/svf_param_ramp.sv
// Smooths F/Q1 coefficient updates for the state-variable filter, stepping once
// per falling edge of the sample strobe toward the most recently accepted target.
module svf_param_ramp
  import filter_pkg::*;
#(
  parameter int STEP_SHIFT = 6,
  parameter int F_RESET    = 13176,
  parameter int Q1_RESET   = 92682
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     sample_clk,
  input  logic signed [COEF_W-1:0] tgt_f,
  input  logic signed [COEF_W-1:0] tgt_q1,
  input  logic                     tgt_valid,
  output logic                     tgt_ready,
  output logic signed [COEF_W-1:0] F,
  output logic signed [COEF_W-1:0] Q1,
  output logic                     settled
);

  ramp_state_t state_reg, state_next;

  logic signed [COEF_W-1:0] f_reg, q1_reg;
  logic signed [COEF_W-1:0] tf_reg, tq_reg;
  logic signed [COEF_W-1:0] f_next, q1_next;
  logic signed [COEF_W-1:0] tgt_f_clamped, tgt_q1_clamped;
  logic                     sclk_prev_reg;
  logic                     tick;
  logic                     accept;

  assign tgt_f_clamped  = clamp_coef(tgt_f, F_MAX);
  assign tgt_q1_clamped = clamp_coef(tgt_q1, Q1_MAX);
  assign tick           = sclk_prev_reg & ~sample_clk;
  assign accept         = tgt_valid & tgt_ready;

  svf_slew_step #(.STEP_SHIFT(STEP_SHIFT)) u_step_f (
    .cur      (f_reg),
    .target   (tf_reg),
    .next_val (f_next)
  );

  svf_slew_step #(.STEP_SHIFT(STEP_SHIFT)) u_step_q1 (
    .cur      (q1_reg),
    .target   (tq_reg),
    .next_val (q1_next)
  );

  always_comb begin
    state_next = state_reg;
    tgt_ready  = 1'b1;
    settled    = 1'b0;
    case (state_reg)
      IDLE: begin
        settled = 1'b1;
        if (accept && (tgt_f_clamped != f_reg || tgt_q1_clamped != q1_reg)) begin
          state_next = RAMP;
        end
      end
      RAMP: begin
        if (tick) state_next = STEP;
      end
      STEP: begin
        tgt_ready  = 1'b0;
        state_next = (f_next == tf_reg && q1_next == tq_reg) ? IDLE : RAMP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      f_reg         <= COEF_W'(F_RESET);
      q1_reg        <= COEF_W'(Q1_RESET);
      tf_reg        <= COEF_W'(F_RESET);
      tq_reg        <= COEF_W'(Q1_RESET);
      sclk_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sclk_prev_reg <= sample_clk;
      // A target taken in the tick cycle is already in place for the STEP that follows.
      if (accept) begin
        tf_reg <= tgt_f_clamped;
        tq_reg <= tgt_q1_clamped;
      end
      if (state_reg == STEP) begin
        f_reg  <= f_next;
        q1_reg <= q1_next;
      end
    end
  end

  assign F  = f_reg;
  assign Q1 = q1_reg;

endmodule

// File: tb/tb_svf_param_ramp.sv
// Directed bench for svf_param_ramp: a STEP_SHIFT=6 instance plus a STEP_SHIFT=0 instance.
module tb_svf_param_ramp;

  logic clk = 1'b0;
  logic resetn;
  logic sample_clk;
  logic signed [19:0] tgt_f, tgt_q1;
  logic tgt_valid;

  logic tgt_ready, settled, tgt_ready0, settled0;
  logic signed [19:0] f_out, q1_out, f_out0, q1_out0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  svf_param_ramp #(.STEP_SHIFT(6)) dut (
    .clk(clk), .resetn(resetn), .sample_clk(sample_clk),
    .tgt_f(tgt_f), .tgt_q1(tgt_q1), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .F(f_out), .Q1(q1_out), .settled(settled)
  );

  svf_param_ramp #(.STEP_SHIFT(0)) dut0 (
    .clk(clk), .resetn(resetn), .sample_clk(sample_clk),
    .tgt_f(tgt_f), .tgt_q1(tgt_q1), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready0),
    .F(f_out0), .Q1(q1_out0), .settled(settled0)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic accept_pair(input int f, input int q);
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_f     = 20'(f);
    tgt_q1    = 20'(q);
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  // Strobe high for one cycle, then low; returns once the resulting STEP (if any) is visible.
  task automatic do_tick();
    @(negedge clk) sample_clk = 1'b1;
    @(negedge clk) sample_clk = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int prev_f;
    bit mono_ok;
    bit range_ok;

    resetn = 1'b0; sample_clk = 1'b0; tgt_valid = 1'b0; tgt_f = '0; tgt_q1 = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check_val("reset_F", int'(f_out), 13176);
    check_val("reset_Q1", int'(q1_out), 92682);
    check_val("reset_settled", settled, 1);
    check_val("reset_ready", tgt_ready, 1);

    // Identical target: stays idle; idle tick changes nothing
    accept_pair(13176, 92682);
    do_tick();
    check_val("same_tgt_settled", settled, 1);
    check_val("idle_tick_F", int'(f_out), 13176);

    // Small ramp: 640 >>> 6 = 10
    accept_pair(13816, 92682);
    check_val("ramp_settled_low", settled, 0);
    do_tick();
    check_val("ramp_first_F", int'(f_out), 13186);
    check_val("ramp_first_Q1", int'(q1_out), 92682);
    prev_f = 13186;
    mono_ok = 1'b1;
    for (int i = 0; i < 1000 && !settled; i++) begin
      do_tick();
      if (int'(f_out) < prev_f || int'(f_out) > 13816) mono_ok = 1'b0;
      prev_f = int'(f_out);
    end
    check_val("ramp_final_F", int'(f_out), 13816);
    check_val("ramp_settled", settled, 1);
    check_val("ramp_monotonic", mono_ok, 1);

    // Clamp: -5 -> 0, 200000 -> 131072
    accept_pair(-5, 200000);
    do_tick();
    check_val("clamp_first_F", int'(f_out), 13600);   // -13816>>>6 = -216
    check_val("clamp_first_Q1", int'(q1_out), 93281); // 38390>>>6 = 599
    range_ok = 1'b1;
    for (int i = 0; i < 1500 && !settled; i++) begin
      do_tick();
      if (f_out < 0 || f_out > 288358 || q1_out < 0 || q1_out > 131072) range_ok = 1'b0;
    end
    check_val("clamp_final_F", int'(f_out), 0);
    check_val("clamp_final_Q1", int'(q1_out), 131072);
    check_val("clamp_in_range", range_ok, 1);

    // Retarget in the tick cycle; an offer during STEP is refused
    accept_pair(6400, 131072);
    check_val("retgt_ready_ramp", tgt_ready, 1);
    @(negedge clk) sample_clk = 1'b1;
    @(negedge clk);
    sample_clk = 1'b0;
    tgt_valid = 1'b1; tgt_f = 20'sd64000; tgt_q1 = 20'sd131072;
    @(negedge clk);
    check_val("retgt_ready_step", tgt_ready, 0);
    tgt_f = 20'sd0;
    @(negedge clk);
    tgt_valid = 1'b0;
    check_val("retgt_F", int'(f_out), 1000);
    check_val("retgt_ready_after", tgt_ready, 1);
    do_tick();
    check_val("retgt_refused_F", int'(f_out), 1984);

    // Reset pulse mid-ramp
    @(negedge clk) resetn = 1'b0;
    @(negedge clk) resetn = 1'b1;
    check_val("midrst_F", int'(f_out), 13176);
    check_val("midrst_Q1", int'(q1_out), 92682);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      check_val($sformatf("midrst_tick%0d_settled", i), settled, 1);
      check_val($sformatf("midrst_tick%0d_F", i), int'(f_out), 13176);
    end

    // One-tick convergence with STEP_SHIFT=0
    accept_pair(100000, 0);
    check_val("shift0_settled_low", settled0, 0);
    do_tick();
    check_val("shift0_F", int'(f_out0), 100000);
    check_val("shift0_Q1", int'(q1_out0), 0);
    check_val("shift0_settled", settled0, 1);
    check_val("shift6_F", int'(f_out), 14532);   // 86824>>>6 = 1356
    check_val("shift6_Q1", int'(q1_out), 91233); // -92682>>>6 = -1449

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
